// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, 3-sample majority vote, single-entry valid/ready output.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects sense) and the parity_err port.
module uart_rx #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic       pll_clk,
   input  logic       n_rst,
   input  logic       tick16,
   input  logic       rxd,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_err
`endif
);

   localparam int unsigned IDX_W = 3;
   localparam int unsigned CNT_W = 4;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
`endif
   localparam logic [2:0] STOP   = 3'd4;

   logic                 sync1, rxd_s, rxd_d;
   logic [2:0]           state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [IDX_W-1:0]     idx, idx_n;
   logic [DATA_BITS-1:0] shift, shift_n;
   logic [1:0]           samp, samp_n;
   logic [7:0]           data_n;
   logic                 valid_n, ferr_n, ovr_n;
   logic                 fall_c, maj_c, mid_c, wrap_c, deliver_c;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad, par_bad_n, perr_n;
`else
   logic                 unused_par_cfg;
   assign unused_par_cfg = 1'(PARITY_ODD);
`endif

   // Two-flop synchronizer plus one delay flop for falling-edge detection
   always_ff @(posedge pll_clk or negedge n_rst) begin
      if (!n_rst) begin
         sync1 <= 1'b1;
         rxd_s <= 1'b1;
         rxd_d <= 1'b1;
      end else begin
         sync1 <= rxd;
         rxd_s <= sync1;
         rxd_d <= rxd_s;
      end
   end

   assign fall_c = rxd_d & ~rxd_s;
   assign mid_c  = tick16 && (cnt == CNT_W'(9));
   assign wrap_c = tick16 && (cnt == CNT_W'(15));
   // Samples at cnt 7 and 8 are stored; the cnt 9 sample is the live synced line
   assign maj_c  = (samp[0] & samp[1]) | (samp[0] & rxd_s) | (samp[1] & rxd_s);

   always_ff @(posedge pll_clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shift     <= '0;
         samp      <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         shift     <= shift_n;
         samp      <= samp_n;
         rx_data   <= data_n;
         rx_valid  <= valid_n;
         frame_err <= ferr_n;
         overrun   <= ovr_n;
`ifdef UART_RX_PARITY_EN
         par_bad    <= par_bad_n;
         parity_err <= perr_n;
`endif
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      idx_n     = idx;
      shift_n   = shift;
      samp_n    = samp;
      data_n    = rx_data;
      valid_n   = rx_valid;
      ferr_n    = 1'b0;
      ovr_n     = 1'b0;
      deliver_c = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_n = par_bad;
      perr_n    = 1'b0;
`endif

      if (rx_valid && rx_ready) valid_n = 1'b0;

      if (tick16) begin
         cnt_n = cnt + CNT_W'(1);
         if (cnt == CNT_W'(7)) samp_n[0] = rxd_s;
         if (cnt == CNT_W'(8)) samp_n[1] = rxd_s;
      end

      case (state)
         IDLE: begin
            cnt_n = '0;
            idx_n = '0;
            if (fall_c) state_n = START;
         end
         START: begin
            if (mid_c && maj_c) state_n = IDLE;
            else if (wrap_c) begin
               state_n = DATA;
               idx_n   = '0;
            end
         end
         DATA: begin
            if (mid_c) shift_n = {maj_c, shift[DATA_BITS-1:1]};
            if (wrap_c) begin
               if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  idx_n = idx + IDX_W'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (mid_c) par_bad_n = maj_c ^ (^shift) ^ 1'(PARITY_ODD);
            if (wrap_c) state_n = STOP;
         end
`endif
         STOP: begin
            // Decide mid stop bit and leave at once so the next start edge is caught
            if (mid_c) begin
               state_n = IDLE;
               if (!maj_c) ferr_n = 1'b1;
`ifdef UART_RX_PARITY_EN
               else if (par_bad) perr_n = 1'b1;
`endif
               else deliver_c = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      if (deliver_c) begin
         if (!rx_valid || rx_ready) begin
            data_n  = 8'(shift);
            valid_n = 1'b1;
         end else begin
            ovr_n = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; frames driven bit by bit against a 1-in-4 tick16.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx;

   localparam int unsigned DATA_BITS  = 8;
   localparam int unsigned PARITY_ODD = 0;

   logic       pll_clk;
   logic       n_rst;
   logic       tick16;
   logic       rxd;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   int checks = 0;
   int errors = 0;
   int hs_cnt = 0;
   int valid_cyc = 0;
   int ferr_cnt = 0;
   int ovr_cnt = 0;
   int perr_cnt = 0;
   int tdiv = 0;
   int h0, v0, f0, o0, p0;
   logic [7:0] exp_q[$];

   uart_rx #(.DATA_BITS(DATA_BITS), .PARITY_ODD(PARITY_ODD)) dut (
      .pll_clk   (pll_clk),
      .n_rst     (n_rst),
      .tick16    (tick16),
      .rxd       (rxd),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err(parity_err)
`endif
   );

   initial pll_clk = 1'b0;
   always #5 pll_clk = ~pll_clk;

   // Baud generator stand-in: one tick every 4 clocks
   initial begin
      tick16 = 1'b0;
      forever begin
         @(negedge pll_clk);
         tick16 = (tdiv == 3);
         tdiv = (tdiv + 1) % 4;
      end
   end

   // Output monitor: pops the scoreboard on each accepted byte, counts pulses
   always @(negedge pll_clk) begin
      if (n_rst === 1'b1) begin
         if (rx_valid === 1'b1) valid_cyc++;
         if (frame_err === 1'b1) ferr_cnt++;
         if (overrun === 1'b1) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
         if (parity_err === 1'b1) perr_cnt++;
`endif
         if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            logic [7:0] e;
            hs_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_unexpected: got rx_data=%02h expected no byte", rx_data);
            end else begin
               e = exp_q.pop_front();
               if (rx_data !== e) begin
                  errors++;
                  $display("FAIL scoreboard_data: got %02h expected %02h", rx_data, e);
               end
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge pll_clk);
         while (tick16 !== 1'b1) @(posedge pll_clk);
      end
      @(negedge pll_clk);
   endtask

   task automatic set_ready(input logic v);
      @(posedge pll_clk);
      #1 rx_ready = v;
   endtask

   task automatic snap();
      h0 = hs_cnt; v0 = valid_cyc; f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int glitch_bit,
                             input logic bad_par);
      rxd = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < int'(DATA_BITS); i++) begin
         rxd = d[i];
         if (i == glitch_bit) begin
            wait_ticks(8);
            rxd = ~d[i];
            wait_ticks(1);
            rxd = d[i];
            wait_ticks(7);
         end else begin
            wait_ticks(16);
         end
      end
`ifdef UART_RX_PARITY_EN
      rxd = (^d[DATA_BITS-1:0]) ^ 1'(PARITY_ODD) ^ bad_par;
      wait_ticks(16);
`else
      if (bad_par) rxd = 1'b1;
`endif
      rxd = stop_bit;
      wait_ticks(16);
      rxd = 1'b1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0; rxd = 1'b1; rx_ready = 1'b0;
      repeat (3) @(negedge pll_clk);
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %02h expected 00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
`ifdef UART_RX_PARITY_EN
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
`endif
      n_rst = 1'b1;
      wait_ticks(4);
   endtask

   task automatic test_basic();
      set_ready(1'b1);
      wait_ticks(1);
      snap();
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, -1, 1'b0);
      wait_ticks(4);
      checks++; if (hs_cnt - h0 != 1) begin errors++; $display("FAIL basic_bytes: got %0d expected 1", hs_cnt - h0); end
      checks++; if (valid_cyc - v0 != 1) begin errors++; $display("FAIL basic_valid_width: got %0d expected 1", valid_cyc - v0); end
      checks++; if (ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin
         errors++; $display("FAIL basic_flags: got ferr=%0d ovr=%0d expected 0 0", ferr_cnt - f0, ovr_cnt - o0);
      end
   endtask

   task automatic test_false_start();
      snap();
      rxd = 1'b0;
      wait_ticks(5);
      rxd = 1'b1;
      wait_ticks(24);
      checks++; if (valid_cyc - v0 != 0) begin errors++; $display("FAIL false_start_valid: got %0d expected 0", valid_cyc - v0); end
      checks++; if (ferr_cnt - f0 != 0) begin errors++; $display("FAIL false_start_ferr: got %0d expected 0", ferr_cnt - f0); end
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, -1, 1'b0);
      wait_ticks(4);
      checks++; if (hs_cnt - h0 != 1) begin errors++; $display("FAIL false_start_resync: got %0d expected 1", hs_cnt - h0); end
   endtask

   task automatic test_frame_err();
      snap();
      send_frame(8'h3C, 1'b0, -1, 1'b0);
      wait_ticks(16);
      checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL frame_err_pulse: got %0d cycles expected 1", ferr_cnt - f0); end
      checks++; if (valid_cyc - v0 != 0) begin errors++; $display("FAIL frame_err_valid: got %0d expected 0", valid_cyc - v0); end
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1, -1, 1'b0);
      wait_ticks(4);
      checks++; if (hs_cnt - h0 != 1) begin errors++; $display("FAIL frame_err_next: got %0d expected 1", hs_cnt - h0); end
      checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL frame_err_next_ferr: got %0d expected 1", ferr_cnt - f0); end
   endtask

   task automatic test_overrun();
      set_ready(1'b0);
      wait_ticks(1);
      snap();
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, -1, 1'b0);
      wait_ticks(4);
      send_frame(8'h22, 1'b1, -1, 1'b0);
      wait_ticks(4);
      checks++; if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL overrun_pulse: got %0d cycles expected 1", ovr_cnt - o0); end
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid_held: got %b expected 1", rx_valid); end
      checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL overrun_data_held: got %02h expected 11", rx_data); end
      set_ready(1'b1);
      @(posedge pll_clk);
      #1;
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_accept_valid: got %b expected 0", rx_valid); end
      checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL overrun_accept_data: got %02h expected 11", rx_data); end
      checks++; if (hs_cnt - h0 != 1) begin errors++; $display("FAIL overrun_bytes: got %0d expected 1", hs_cnt - h0); end
   endtask

   task automatic test_glitch();
      wait_ticks(2);
      snap();
      exp_q.push_back(8'h00);
      send_frame(8'h00, 1'b1, 3, 1'b0);
      wait_ticks(4);
      checks++; if (hs_cnt - h0 != 1) begin errors++; $display("FAIL glitch_bytes: got %0d expected 1", hs_cnt - h0); end
      checks++; if (ferr_cnt - f0 != 0) begin errors++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt - f0); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b;
      snap();
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom_range(0, 255));
         exp_q.push_back(b);
         send_frame(b, 1'b1, -1, 1'b0);
      end
      wait_ticks(4);
      checks++; if (hs_cnt - h0 != 6) begin errors++; $display("FAIL b2b_bytes: got %0d expected 6", hs_cnt - h0); end
      checks++; if (valid_cyc - v0 != 6) begin errors++; $display("FAIL b2b_valid_cycles: got %0d expected 6", valid_cyc - v0); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      snap();
      send_frame(8'h07, 1'b1, -1, 1'b1);
      wait_ticks(4);
      checks++; if (perr_cnt - p0 != 1) begin errors++; $display("FAIL parity_err_pulse: got %0d cycles expected 1", perr_cnt - p0); end
      checks++; if (valid_cyc - v0 != 0) begin errors++; $display("FAIL parity_err_valid: got %0d expected 0", valid_cyc - v0); end
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1, -1, 1'b0);
      wait_ticks(4);
      checks++; if (hs_cnt - h0 != 1) begin errors++; $display("FAIL parity_good_bytes: got %0d expected 1", hs_cnt - h0); end
      checks++; if (perr_cnt - p0 != 1) begin errors++; $display("FAIL parity_good_perr: got %0d expected 1", perr_cnt - p0); end
   endtask
`endif

   task automatic test_reset_mid_frame();
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, -1, 1'b0);
      wait_ticks(2);
      rxd = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 3; i++) begin
         rxd = 1'(i % 2);
         wait_ticks(16);
      end
      n_rst = 1'b0;
      @(posedge pll_clk);
      #1;
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_rx_data: got %02h expected 00", rx_data); end
      checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
         errors++; $display("FAIL midrst_flags: got v=%b f=%b o=%b expected 0 0 0", rx_valid, frame_err, overrun);
      end
      rxd = 1'b1;
      repeat (3) @(negedge pll_clk);
      n_rst = 1'b1;
      snap();
      wait_ticks(24);
      checks++; if (ferr_cnt - f0 != 0 || valid_cyc - v0 != 0 || perr_cnt - p0 != 0) begin
         errors++; $display("FAIL midrst_after: got ferr=%0d valid=%0d perr=%0d expected 0 0 0",
                            ferr_cnt - f0, valid_cyc - v0, perr_cnt - p0);
      end
      exp_q.push_back(8'hC3);
      send_frame(8'hC3, 1'b1, -1, 1'b0);
      wait_ticks(4);
      checks++; if (hs_cnt - h0 != 1) begin errors++; $display("FAIL midrst_next: got %0d expected 1", hs_cnt - h0); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_false_start();
      test_frame_err();
      test_overrun();
      test_glitch();
      test_back_to_back();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_reset_mid_frame();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d bytes pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
